// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches via a req/ready memory handshake and
// drives the IF/ID register write, bubble, PC+4 and instruction fields.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        ifid_write,
  output logic        ifid_flush
);

  typedef enum logic [1:0] {StReq, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic        ifid_write_q, ifid_write_d;
  logic        ifid_flush_q, ifid_flush_d;

  logic        accept;
  logic        redir;
  logic        capture;
  logic [31:0] target;
  logic [31:0] pc_inc;

  // A ready strobe only counts while a request is actually on the bus.
  assign accept = imem_ready & imem_req_q;
  assign redir  = exception | redirect;
  assign target = exception ? EXC_PC : redirect_pc;
  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      pc_out_q     <= '0;
      instr_out_q  <= '0;
      ifid_write_q <= 1'b0;
      ifid_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      pc_out_q     <= pc_out_d;
      instr_out_q  <= instr_out_d;
      ifid_write_q <= ifid_write_d;
      ifid_flush_q <= ifid_flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    capture = 1'b0;
    case (state_q)
      StReq: begin
        if (redir) begin
          pc_d = target;
          // An outstanding request must be drained before fetching the target.
          state_d = (imem_req_q && !accept) ? StDrain : StReq;
        end else if (accept) begin
          capture = 1'b1;
          if (pc_write) pc_d = pc_inc;
          else          state_d = StHold;
        end
      end
      StHold: begin
        if (redir) begin
          pc_d    = target;
          state_d = StReq;
        end else if (pc_write) begin
          pc_d    = pc_inc;
          state_d = StReq;
        end
      end
      StDrain: begin
        if (redir)  pc_d = target;
        if (accept) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  always_comb begin
    imem_req_d   = (state_d != StHold);
    imem_addr_d  = (state_d == StDrain) ? imem_addr_q : pc_d;
    ifid_write_d = capture;
    ifid_flush_d = redir;
    instr_out_d  = capture ? imem_rdata : instr_out_q;
    pc_out_d     = capture ? pc_inc : pc_out_q;
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign pc_out     = pc_out_q;
  assign instr_out  = instr_out_q;
  assign ifid_write = ifid_write_q;
  assign ifid_flush = ifid_flush_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: inputs change 1ns after each rising edge and
// registered outputs are checked at that same point.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exception;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        ifid_write;
  logic        ifid_flush;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc_write   (pc_write),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .exception  (exception),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full output snapshot: req, addr, pc_out, instr_out, write, flush.
  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic [31:0] pco, input logic [31:0] ins,
                         input logic wr, input logic fl);
    chk({tag, ".req"},   {31'd0, imem_req},   {31'd0, req});
    chk({tag, ".addr"},  imem_addr,           addr);
    chk({tag, ".pcout"}, pc_out,              pco);
    chk({tag, ".instr"}, instr_out,           ins);
    chk({tag, ".wr"},    {31'd0, ifid_write}, {31'd0, wr});
    chk({tag, ".fl"},    {31'd0, ifid_flush}, {31'd0, fl});
  endtask

  initial begin
    reset = 1'b1; pc_write = 1'b1; redirect = 1'b0; redirect_pc = '0;
    exception = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    #1;
    step(); step();
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // 1: sequential fetch, ready one cycle after request
    reset = 1'b0;
    step();
    chk_all("t1.req0", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hA000_0000;
    step();
    chk_all("t1.w0", 1'b1, 32'h4, 32'h4, 32'hA000_0000, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();
    chk_all("t1.gap0", 1'b1, 32'h4, 32'h4, 32'hA000_0000, 1'b0, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hA000_0004;
    step();
    chk_all("t1.w1", 1'b1, 32'h8, 32'h8, 32'hA000_0004, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();

    // 2: stall on fetch of 8, stray ready during HOLD is ignored
    imem_ready = 1'b1; imem_rdata = 32'hA000_0008; pc_write = 1'b0;
    step();
    chk_all("t2.w2", 1'b0, 32'h8, 32'hC, 32'hA000_0008, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();
    chk_all("t2.hold1", 1'b0, 32'h8, 32'hC, 32'hA000_0008, 1'b0, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk_all("t2.hold2", 1'b0, 32'h8, 32'hC, 32'hA000_0008, 1'b0, 1'b0);
    imem_ready = 1'b0; pc_write = 1'b1;
    step();
    chk_all("t2.release", 1'b1, 32'hC, 32'hC, 32'hA000_0008, 1'b0, 1'b0);

    // 3: redirect to 0x40 while C is in flight
    step();
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    chk_all("t3.flush", 1'b1, 32'hC, 32'hC, 32'hA000_0008, 1'b0, 1'b1);
    redirect = 1'b0;
    step();
    chk_all("t3.drain", 1'b1, 32'hC, 32'hC, 32'hA000_0008, 1'b0, 1'b0);
    step();
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_000C;
    step();
    chk_all("t3.drop", 1'b1, 32'h40, 32'hC, 32'hA000_0008, 1'b0, 1'b0);
    imem_ready = 1'b0;
    step();

    // 4: exception beats redirect, arriving with ready
    exception = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_0040;
    step();
    chk_all("t4.exc", 1'b1, 32'h8000_0004, 32'hC, 32'hA000_0008, 1'b0, 1'b1);
    exception = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    step();
    chk_all("t4.after", 1'b1, 32'h8000_0004, 32'hC, 32'hA000_0008, 1'b0, 1'b0);
    imem_ready = 1'b1; imem_rdata = 32'hE000_0004;
    step();
    chk_all("t4.fetch", 1'b1, 32'h8000_0008, 32'h8000_0008, 32'hE000_0004, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();

    // 5: double redirect in DRAIN, then reset mid-DRAIN
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    chk_all("t5.r1", 1'b1, 32'h8000_0008, 32'h8000_0008, 32'hE000_0004, 1'b0, 1'b1);
    redirect_pc = 32'h200;
    step();
    chk_all("t5.r2", 1'b1, 32'h8000_0008, 32'h8000_0008, 32'hE000_0004, 1'b0, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h300; reset = 1'b1;
    step();
    chk_all("t5.reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    redirect = 1'b0; reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0300;
    step();
    chk_all("t5.late", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    imem_rdata = 32'hA100_0000;
    step();
    chk_all("t5.restart", 1'b1, 32'h4, 32'h4, 32'hA100_0000, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();

    // 6: PC wrap at FFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    chk_all("t6.redir", 1'b1, 32'h4, 32'h4, 32'hA100_0000, 1'b0, 1'b1);
    redirect = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hBAD0_0004;
    step();
    chk_all("t6.drain", 1'b1, 32'hFFFF_FFFC, 32'h4, 32'hA100_0000, 1'b0, 1'b0);
    imem_ready = 1'b0;
    step();
    imem_ready = 1'b1; imem_rdata = 32'hF000_FFFC;
    step();
    chk_all("t6.wrap", 1'b1, 32'h0, 32'h0, 32'hF000_FFFC, 1'b1, 1'b0);
    imem_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
